icache_lite: RTL and testbench

ICACHE_LITE -- requirements
Module: icache_lite

---
 rtl/icache_lite.sv | 156 +++++++++++++++
 tb/tb_icache_lite.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_lite.sv
// Direct-mapped instruction cache, 4-word lines, single outstanding line fill.
// Hits return the word one cycle after address capture; misses stall in MISS until mem_ack.

module icache_line #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 wr,
  input  logic [TAG_W-1:0]     wtag,
  input  logic [3:0][XLEN-1:0] wdata,
  output logic                 valid,
  output logic [TAG_W-1:0]     tag,
  output logic [3:0][XLEN-1:0] data
);
  // wr (MISS) and clr (FLUSH) never coincide
  always_ff @(posedge clk) begin
    if (!rst_n)   valid <= 1'b0;
    else if (wr)  valid <= 1'b1;
    else if (clr) valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      tag  <= wtag;
      data <= wdata;
    end
  end
endmodule

module icache_lite #(
  parameter int NUM_LINES = 16,
  parameter int XLEN      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_addr,
  input  logic              if_req,
  input  logic              if_req_kill,
  input  logic              if_icache_flush,
  output logic              if_ack,
  output logic [XLEN-1:0]   if_r_data,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  input  logic [4*XLEN-1:0] mem_r_data,
  input  logic              mem_ack
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = XLEN - 4 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MISS, S_FLUSH} state_t;

  state_t           state;
  logic [XLEN-1:0]  req_addr;
  logic             killed;
  logic             flush_pend;
  logic [IDX_W-1:0] flush_cnt;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_off;
  logic             hit;
  logic             fill_we;
  logic             unused_bits;

  logic [NUM_LINES-1:0]                 line_valid;
  logic [NUM_LINES-1:0][TAG_W-1:0]      line_tag;
  logic [NUM_LINES-1:0][3:0][XLEN-1:0]  line_data;
  logic [3:0][XLEN-1:0]                 fill_words;

  assign req_idx     = req_addr[4 +: IDX_W];
  assign req_tag     = req_addr[XLEN-1 -: TAG_W];
  assign req_off     = req_addr[3:2];
  assign unused_bits = ^req_addr[1:0];
  assign fill_words  = mem_r_data;
  assign fill_we     = rst_n && (state == S_MISS) && mem_ack;

  assign hit = line_valid[req_idx] && (line_tag[req_idx] == req_tag);

  // kill and flush suppress the ack combinationally in the cycle they arrive
  assign if_ack    = rst_n && (state == S_LOOKUP) && hit && !if_req_kill && !if_icache_flush;
  assign if_r_data = if_ack ? line_data[req_idx][req_off] : '0;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    icache_line #(.XLEN(XLEN), .TAG_W(TAG_W)) u_line (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   ((state == S_FLUSH) && (flush_cnt == IDX_W'(i))),
      .wr    (fill_we && (req_idx == IDX_W'(i))),
      .wtag  (req_tag),
      .wdata (fill_words),
      .valid (line_valid[i]),
      .tag   (line_tag[i]),
      .data  (line_data[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_addr   <= '0;
      killed     <= 1'b0;
      flush_pend <= 1'b0;
      flush_cnt  <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (if_icache_flush) state <= S_FLUSH;
          else if (if_req) begin
            req_addr <= if_addr;
            state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (if_icache_flush) state <= S_FLUSH;
          else if (if_req_kill || hit) begin
            if (if_req) req_addr <= if_addr;
            else        state    <= S_IDLE;
          end else begin
            state    <= S_MISS;
            mem_req  <= 1'b1;
            mem_addr <= {req_addr[XLEN-1:4], 4'b0};
          end
        end
        S_MISS: begin
          // the fill always lands; kill/flush only redirect where we go afterwards
          if (mem_ack) begin
            mem_req    <= 1'b0;
            killed     <= 1'b0;
            flush_pend <= 1'b0;
            if (flush_pend || if_icache_flush)  state <= S_FLUSH;
            else if (killed || if_req_kill)     state <= S_IDLE;
            else                                state <= S_LOOKUP;
          end else begin
            if (if_req_kill)     killed     <= 1'b1;
            if (if_icache_flush) flush_pend <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == LAST_IDX) begin
            flush_cnt <= '0;
            state     <= S_IDLE;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_lite.sv
// Directed bench for icache_lite: line-level cache model plus per-cycle expected outputs.
module tb_icache_lite;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  if_addr;
  logic         if_req, if_req_kill, if_icache_flush;
  logic         if_ack;
  logic [31:0]  if_r_data;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic [127:0] mem_r_data;
  logic         mem_ack;

  icache_lite #(.NUM_LINES(16), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_addr(if_addr), .if_req(if_req),
    .if_req_kill(if_req_kill), .if_icache_flush(if_icache_flush),
    .if_ack(if_ack), .if_r_data(if_r_data), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_r_data(mem_r_data), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        chk_en = 1'b0;
  logic        exp_ack, exp_mreq, chk_maddr0;
  logic [31:0] exp_data, exp_maddr;

  // model: which memory line each index holds (memory content is a pure function of address)
  logic        mvalid [16];
  logic [23:0] mtag   [16];

  task automatic chk1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, req);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, req);
    end
  endtask

  function automatic logic [127:0] mem_line(input logic [31:0] la);
    logic [127:0] l;
    if (la == 32'h8000_0000) l = {32'h33, 32'h22, 32'h11, 32'h00};
    else for (int k = 0; k < 4; k++) l[32*k +: 32] = la ^ (32'h0BAD_0000 + 32'(k));
    return l;
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [127:0] l;
    l = mem_line({a[31:4], 4'b0});
    return l[32*a[3:2] +: 32];
  endfunction

  function automatic logic cached(input logic [31:0] a);
    return mvalid[a[7:4]] && (mtag[a[7:4]] == a[31:8]);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("if_ack", if_ack, exp_ack);
      chk32("if_r_data", if_r_data, exp_data);
      chk1("mem_req", mem_req, exp_mreq);
      if (exp_mreq || chk_maddr0) chk32("mem_addr", mem_addr, exp_maddr);
    end
  end

  // advance one cycle; inputs and expectations default to idle
  task automatic cyc();
    @(posedge clk);
    #1;
    if_req = 1'b0; if_req_kill = 1'b0; if_icache_flush = 1'b0;
    mem_ack = 1'b0; mem_r_data = '0;
    exp_ack = 1'b0; exp_data = '0; exp_mreq = 1'b0; exp_maddr = '0; chk_maddr0 = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  task automatic flush_run();
    for (int i = 0; i < 16; i++) begin
      cyc();
      if_req = 1'b1; if_addr = 32'h8000_0004;
    end
    clear_model();
  endtask

  // one fetch from IDLE; kill_at/flush_at index the MISS cycles (-1 = never)
  task automatic fetch(input logic [31:0] a, input int lat, input int kill_at, input int flush_at,
                       input logic pin_en, input logic [31:0] pin_maddr, input logic [31:0] pin_word);
    logic [31:0] la;
    la = {a[31:4], 4'b0};
    cyc(); if_req = 1'b1; if_addr = a;
    cyc(); if_req = 1'b1; if_addr = a;
    if (cached(a)) begin
      if_req = 1'b0; exp_ack = 1'b1; exp_data = word(a);
      if (pin_en) begin @(negedge clk); chk32("pin_hit_data", if_r_data, pin_word); end
      return;
    end
    for (int c = 0; c <= lat; c++) begin
      cyc();
      if_req = 1'b1; if_addr = a ^ 32'h40;
      exp_mreq = 1'b1; exp_maddr = la;
      if (c == kill_at)  if_req_kill = 1'b1;
      if (c == flush_at) if_icache_flush = 1'b1;
      if (c == lat) begin mem_ack = 1'b1; mem_r_data = mem_line(la); end
      if (pin_en && c == 0) begin @(negedge clk); chk32("pin_mem_addr", mem_addr, pin_maddr); end
    end
    mvalid[a[7:4]] = 1'b1; mtag[a[7:4]] = a[31:8];
    if (flush_at >= 0) flush_run();
    else if (kill_at < 0) begin
      cyc(); exp_ack = 1'b1; exp_data = word(a);
      if (pin_en) begin
        @(negedge clk);
        chk1("pin_fill_ack", if_ack, 1'b1);
        chk32("pin_fill_data", if_r_data, pin_word);
      end
    end
  endtask

  task automatic stream(input logic [31:0] base, input int n);
    cyc(); if_req = 1'b1; if_addr = base;
    for (int i = 1; i < n; i++) begin
      cyc(); if_req = 1'b1; if_addr = base + 32'(4*i);
      exp_ack = 1'b1; exp_data = word(base + 32'(4*(i-1)));
    end
    cyc(); exp_ack = 1'b1; exp_data = word(base + 32'(4*(n-1)));
  endtask

  task automatic kill_lookup(input logic [31:0] a, input logic newreq, input logic [31:0] b);
    cyc(); if_req = 1'b1; if_addr = a;
    cyc(); if_req_kill = 1'b1; if_req = newreq; if_addr = b;
    if (newreq) begin
      cyc(); exp_ack = 1'b1; exp_data = word(b);
    end
  endtask

  task automatic lookup_flush(input logic [31:0] a, input logic kill);
    cyc(); if_req = 1'b1; if_addr = a;
    cyc(); if_icache_flush = 1'b1; if_req_kill = kill; if_req = 1'b1;
    flush_run();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_addr = '0; if_req = 1'b0; if_req_kill = 1'b0; if_icache_flush = 1'b0;
    mem_ack = 1'b0; mem_r_data = '0;
    exp_ack = 1'b0; exp_data = '0; exp_mreq = 1'b0; exp_maddr = '0; chk_maddr0 = 1'b0;
    clear_model();
    cyc(); cyc();
    chk_en = 1'b1; chk_maddr0 = 1'b1; if_req = 1'b1; if_addr = 32'h8000_0004;
    cyc(); rst_n = 1'b1; chk_maddr0 = 1'b1;

    // cold miss, memory answers 3 cycles after mem_req
    fetch(32'h8000_0004, 3, -1, -1, 1'b1, 32'h8000_0000, 32'h11);
    stream(32'h8000_0000, 4);
    // same-index conflict replaces the line
    fetch(32'h8000_0100, 2, -1, -1, 1'b1, 32'h8000_0100, 32'h8000_0100 ^ 32'h0BAD_0000);
    fetch(32'h8000_0000, 1, -1, -1, 1'b1, 32'h8000_0000, 32'h00);
    // kill one cycle after mem_req: line still filled, no ack
    fetch(32'h8000_0210, 2, 1, -1, 1'b0, '0, '0);
    fetch(32'h8000_0218, 0, -1, -1, 1'b1, '0, 32'h8000_0210 ^ 32'h0BAD_0002);
    fetch(32'h1234_5670, 0, -1, -1, 1'b0, '0, '0);
    kill_lookup(32'h8000_0004, 1'b1, 32'h8000_0218);
    kill_lookup(32'h8000_0008, 1'b0, 32'h0);
    fetch(32'h8000_000C, 0, -1, -1, 1'b1, '0, 32'h33);
    // flush from IDLE, then the old line must miss
    cyc(); if_icache_flush = 1'b1; if_req = 1'b1; if_addr = 32'h8000_0004;
    flush_run();
    fetch(32'h8000_0000, 1, -1, -1, 1'b1, 32'h8000_0000, 32'h00);
    // flush during MISS, and flush+kill during MISS
    fetch(32'h8000_0300, 3, -1, 1, 1'b0, '0, '0);
    fetch(32'h8000_0300, 0, -1, -1, 1'b0, '0, '0);
    fetch(32'h8000_0400, 2, 0, 1, 1'b0, '0, '0);
    // flush+kill in LOOKUP on a hit
    fetch(32'h8000_0404, 1, -1, -1, 1'b0, '0, '0);
    lookup_flush(32'h8000_0404, 1'b1);
    fetch(32'h8000_0404, 0, -1, -1, 1'b0, '0, '0);
    // reset in the middle of a MISS; late mem_ack must not write
    cyc(); if_req = 1'b1; if_addr = 32'h8000_0500;
    cyc(); if_req = 1'b1;
    cyc(); exp_mreq = 1'b1; exp_maddr = 32'h8000_0500; rst_n = 1'b0;
    cyc(); rst_n = 1'b1; mem_ack = 1'b1; mem_r_data = mem_line(32'h8000_0500); chk_maddr0 = 1'b1;
    clear_model();
    cyc();
    fetch(32'h8000_0500, 1, -1, -1, 1'b1, 32'h8000_0500, 32'h8000_0500 ^ 32'h0BAD_0000);
    fetch(32'h8000_0504, 0, -1, -1, 1'b0, '0, '0);
    cyc();
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
